// File: rtl/vpu_top_unit.sv
// rtl/vpu_top_unit.sv - single-request vector unit: read three operands, compute lane-wise, write one result
module vpu_top_unit #(
    parameter int LANES    = 32,
    parameter int ELEM_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int OPCODE_W = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [OPCODE_W-1:0]       req_opcode,
    input  logic [ADDR_W-1:0]         req_src0_addr,
    input  logic [ADDR_W-1:0]         req_src1_addr,
    input  logic [ADDR_W-1:0]         req_src2_addr,
    input  logic [ADDR_W-1:0]         req_dst_addr,
    output logic                      src0_rd_en,
    output logic [ADDR_W-1:0]         src0_rd_addr,
    input  logic                      src0_rvalid,
    input  logic [LANES*ELEM_W-1:0]   src0_rdata,
    output logic                      src1_rd_en,
    output logic [ADDR_W-1:0]         src1_rd_addr,
    input  logic                      src1_rvalid,
    input  logic [LANES*ELEM_W-1:0]   src1_rdata,
    output logic                      src2_rd_en,
    output logic [ADDR_W-1:0]         src2_rd_addr,
    input  logic                      src2_rvalid,
    input  logic [LANES*ELEM_W-1:0]   src2_rdata,
    output logic                      dst_wr_en,
    input  logic                      dst_wr_ready,
    output logic [ADDR_W-1:0]         dst_wr_addr,
    output logic [LANES*ELEM_W-1:0]   dst_wr_data
);

    localparam int DATA_W = LANES * ELEM_W;

    localparam logic [OPCODE_W-1:0] OP_UIADD  = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] OP_UIADD3 = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OP_UIMUL  = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_UISUM  = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_FMAX   = OPCODE_W'(5);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_EXEC,
        S_WRITE
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic                rd_en;
    logic                accept;
    logic [2:0]          rvalid_vec;
    logic [2:0]          got_q;
    logic                all_got;
    logic [OPCODE_W-1:0] opcode_q;
    logic [ADDR_W-1:0]   dst_q;
    logic [DATA_W-1:0]   op0_q;
    logic [DATA_W-1:0]   op1_q;
    logic [DATA_W-1:0]   op2_q;
    logic [DATA_W-1:0]   result_q;
    logic [DATA_W-1:0]   result_nx;
    logic [ELEM_W-1:0]   lane_a;
    logic [ELEM_W-1:0]   lane_b;
    logic [ELEM_W-1:0]   lane_c;
    logic [ELEM_W-1:0]   lane_sum;

    // Ordering key maps bfloat16 onto unsigned order: negatives inverted, positives
    // offset above them, so +0 lands just above -0 and denormals keep exact order.
    function automatic logic [15:0] bf16_max(input logic [15:0] a, input logic [15:0] b);
        logic        a_nan;
        logic        b_nan;
        logic [15:0] ka;
        logic [15:0] kb;
        a_nan = (a[14:7] == 8'hFF) && (a[6:0] != 7'd0);
        b_nan = (b[14:7] == 8'hFF) && (b[6:0] != 7'd0);
        ka    = a[15] ? ~a : (a | 16'h8000);
        kb    = b[15] ? ~b : (b | 16'h8000);
        if (a_nan || b_nan) begin
            return 16'h7FC0;
        end
        return (ka >= kb) ? a : b;
    endfunction

    assign rvalid_vec = {src2_rvalid, src1_rvalid, src0_rvalid};
    // A port counts as done if already latched or delivering data this cycle.
    assign all_got    = &(got_q | rvalid_vec);
    assign accept     = req_valid && req_ready;

    assign src0_rd_en  = rd_en;
    assign src1_rd_en  = rd_en;
    assign src2_rd_en  = rd_en;
    assign dst_wr_addr = dst_q;
    assign dst_wr_data = result_q;

    // State register; reset drops any in-flight request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and control strobes; req_ready is also held low while reset is asserted.
    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        rd_en     = 1'b0;
        dst_wr_en = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = rst_n;
                if (req_valid) begin
                    state_nx = S_READ;
                end
            end
            S_READ: begin
                rd_en    = 1'b1;
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (all_got) begin
                    state_nx = S_EXEC;
                end
            end
            S_EXEC: begin
                state_nx = S_WRITE;
            end
            S_WRITE: begin
                dst_wr_en = 1'b1;
                if (dst_wr_ready) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Request latches, first-rvalid operand capture and result register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opcode_q     <= '0;
            src0_rd_addr <= '0;
            src1_rd_addr <= '0;
            src2_rd_addr <= '0;
            dst_q        <= '0;
            got_q        <= '0;
            op0_q        <= '0;
            op1_q        <= '0;
            op2_q        <= '0;
            result_q     <= '0;
        end else begin
            if (accept) begin
                opcode_q     <= req_opcode;
                src0_rd_addr <= req_src0_addr;
                src1_rd_addr <= req_src1_addr;
                src2_rd_addr <= req_src2_addr;
                dst_q        <= req_dst_addr;
                got_q        <= '0;
            end
            if (state == S_WAIT) begin
                if (src0_rvalid && !got_q[0]) begin
                    op0_q    <= src0_rdata;
                    got_q[0] <= 1'b1;
                end
                if (src1_rvalid && !got_q[1]) begin
                    op1_q    <= src1_rdata;
                    got_q[1] <= 1'b1;
                end
                if (src2_rvalid && !got_q[2]) begin
                    op2_q    <= src2_rdata;
                    got_q[2] <= 1'b1;
                end
            end
            if (state == S_EXEC) begin
                result_q <= result_nx;
            end
        end
    end

    // Lane-wise datapath; reserved opcodes leave the result all zeros.
    always_comb begin
        result_nx = '0;
        lane_sum  = '0;
        lane_a    = '0;
        lane_b    = '0;
        lane_c    = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_a   = op0_q[i*ELEM_W +: ELEM_W];
            lane_b   = op1_q[i*ELEM_W +: ELEM_W];
            lane_c   = op2_q[i*ELEM_W +: ELEM_W];
            lane_sum = lane_sum + lane_a;
            case (opcode_q)
                OP_UIADD:  result_nx[i*ELEM_W +: ELEM_W] = lane_a + lane_b;
                OP_UIADD3: result_nx[i*ELEM_W +: ELEM_W] = lane_a + lane_b + lane_c;
                OP_UIMUL:  result_nx[i*ELEM_W +: ELEM_W] = lane_a * lane_b;
                OP_FMAX:   result_nx[i*ELEM_W +: ELEM_W] = bf16_max(lane_a, lane_b);
                default:   ;
            endcase
        end
        if (opcode_q == OP_UISUM) begin
            result_nx[ELEM_W-1:0] = lane_sum;
        end
    end

endmodule

// File: tb/tb_vpu_top_unit.sv
// tb/tb_vpu_top_unit.sv - directed self-checking bench for vpu_top_unit
module tb_vpu_top_unit;

    localparam int DW = 512;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [3:0]    req_opcode = '0;
    logic [15:0]   req_src0_addr = '0, req_src1_addr = '0, req_src2_addr = '0, req_dst_addr = '0;
    logic          src0_rd_en, src1_rd_en, src2_rd_en;
    logic [15:0]   src0_rd_addr, src1_rd_addr, src2_rd_addr;
    logic          src0_rvalid = 1'b0, src1_rvalid = 1'b0, src2_rvalid = 1'b0;
    logic [DW-1:0] src0_rdata = '0, src1_rdata = '0, src2_rdata = '0;
    logic          dst_wr_en;
    logic          dst_wr_ready = 1'b0;
    logic [15:0]   dst_wr_addr;
    logic [DW-1:0] dst_wr_data;

    int tests = 0;
    int fails = 0;
    int writes = 0;

    logic [DW-1:0] t_wdata;
    logic [15:0]   t_waddr;
    logic [47:0]   t_rd_addrs;
    int            t_rd_lat, t_wr_lat, t_wr_cycles;
    bit            t_unstable, t_timeout, t_busy;

    vpu_top_unit dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_src0_addr(req_src0_addr), .req_src1_addr(req_src1_addr),
        .req_src2_addr(req_src2_addr), .req_dst_addr(req_dst_addr),
        .src0_rd_en(src0_rd_en), .src0_rd_addr(src0_rd_addr), .src0_rvalid(src0_rvalid), .src0_rdata(src0_rdata),
        .src1_rd_en(src1_rd_en), .src1_rd_addr(src1_rd_addr), .src1_rvalid(src1_rvalid), .src1_rdata(src1_rdata),
        .src2_rd_en(src2_rd_en), .src2_rd_addr(src2_rd_addr), .src2_rvalid(src2_rvalid), .src2_rdata(src2_rdata),
        .dst_wr_en(dst_wr_en), .dst_wr_ready(dst_wr_ready),
        .dst_wr_addr(dst_wr_addr), .dst_wr_data(dst_wr_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && dst_wr_en && dst_wr_ready) writes <= writes + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] fill(input logic [15:0] v);
        logic [DW-1:0] r;
        for (int i = 0; i < 32; i++) r[i*16 +: 16] = v;
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [15:0] ref_fmax(input logic [15:0] a, input logic [15:0] b);
        bit an, bn;
        an = (a[14:7] == 8'hFF) && (a[6:0] != 7'd0);
        bn = (b[14:7] == 8'hFF) && (b[6:0] != 7'd0);
        if (an || bn) return 16'h7FC0;
        if (a[15] != b[15]) return a[15] ? b : a;
        if (!a[15]) return (a[14:0] >= b[14:0]) ? a : b;
        return (a[14:0] <= b[14:0]) ? a : b;
    endfunction

    // Drives one full request; dlN = extra WAIT cycles before port N's rvalid, stall = cycles with wr_ready low.
    task automatic do_txn(input logic [3:0] op, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                          input logic [DW-1:0] d2, input logic [15:0] dst,
                          input int dl0, input int dl1, input int dl2, input int stall);
        int n, k, base;
        t_wdata = '0; t_waddr = '0; t_rd_addrs = '0;
        t_rd_lat = -1; t_wr_lat = -1; t_wr_cycles = 0;
        t_unstable = 0; t_timeout = 0; t_busy = 0;
        req_valid = 1'b1; req_opcode = op; req_dst_addr = dst;
        req_src0_addr = dst ^ 16'h1111; req_src1_addr = dst ^ 16'h2222; req_src2_addr = dst ^ 16'h4444;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        if (!req_ready) begin t_timeout = 1; req_valid = 1'b0; return; end
        base = writes;
        @(negedge clk);
        req_valid = 1'b0;
        for (int j = 1; j < 200; j++) begin
            if (writes != base) break;
            if (req_ready) t_busy = 1;
            if (src0_rd_en && t_rd_lat < 0) begin
                t_rd_lat = j;
                t_rd_addrs = {src2_rd_addr, src1_rd_addr, src0_rd_addr};
            end
            if (t_rd_lat > 0) begin
                k = j - t_rd_lat - 1;
                src0_rvalid = (k == dl0) || (k == dl0 + 1);
                src1_rvalid = (k == dl1) || (k == dl1 + 1);
                src2_rvalid = (k == dl2) || (k == dl2 + 1);
                src0_rdata = (k == dl0) ? d0 : rand_data();
                src1_rdata = (k == dl1) ? d1 : rand_data();
                src2_rdata = (k == dl2) ? d2 : rand_data();
            end
            if (dst_wr_en) begin
                if (t_wr_cycles == 0) begin
                    t_wdata = dst_wr_data; t_waddr = dst_wr_addr; t_wr_lat = j;
                end else if (dst_wr_data !== t_wdata || dst_wr_addr !== t_waddr) begin
                    t_unstable = 1;
                end
                t_wr_cycles++;
                dst_wr_ready = (t_wr_cycles > stall);
            end else begin
                dst_wr_ready = 1'b0;
            end
            @(negedge clk);
        end
        if (writes == base) t_timeout = 1;
        src0_rvalid = 1'b0; src1_rvalid = 1'b0; src2_rvalid = 1'b0; dst_wr_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if (req_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b expected 0", req_ready); end
        tests++;
        if ({src0_rd_en, src1_rd_en, src2_rd_en, dst_wr_en} !== 4'b0 || dst_wr_data !== '0 || dst_wr_addr !== 16'h0
            || {src0_rd_addr, src1_rd_addr, src2_rd_addr} !== 48'h0) begin
            fails++; $display("FAIL reset_outputs: got wr_en=%b addr=%h expected all zero", dst_wr_en, dst_wr_addr);
        end
        req_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        tests++;
        if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready: got %b expected 1", req_ready); end
    endtask

    task automatic test_fmax();
        do_txn(4'd5, fill(16'h3F80), fill(16'hC000), rand_data(), 16'h1234, 0, 0, 0, 0);
        tests++;
        if (t_timeout) begin fails++; $display("FAIL fmax_timeout: got timeout expected completion"); end
        tests++;
        if (t_wdata !== fill(16'h3F80)) begin fails++; $display("FAIL fmax_data: got %h expected lanes 3f80", t_wdata[63:0]); end
        tests++;
        if (t_waddr !== 16'h1234) begin fails++; $display("FAIL fmax_addr: got %h expected 1234", t_waddr); end
        tests++;
        if (t_rd_addrs !== {16'h5670, 16'h3016, 16'h0325}) begin
            fails++; $display("FAIL fmax_rd_addr: got %h expected 567030160325", t_rd_addrs);
        end
        tests++;
        if (t_rd_lat !== 1 || t_wr_lat !== 4) begin
            fails++; $display("FAIL min_latency: got rd=%0d wr=%0d expected rd=1 wr=4", t_rd_lat, t_wr_lat);
        end
        tests++;
        if (t_wr_cycles !== 1 || t_busy) begin
            fails++; $display("FAIL fmax_write_once: got cycles=%0d busy=%0d expected 1 0", t_wr_cycles, t_busy);
        end
    endtask

    task automatic test_fmax_special();
        logic [DW-1:0] a, b, e;
        a = '0; b = '0; e = '0;
        a[15:0]   = 16'h7F81; b[15:0]   = 16'h3F80; e[15:0]   = 16'h7FC0;
        a[31:16]  = 16'h0000; b[31:16]  = 16'h8000; e[31:16]  = 16'h0000;
        a[47:32]  = 16'hBF80; b[47:32]  = 16'hC000; e[47:32]  = 16'hBF80;
        a[63:48]  = 16'h0001; b[63:48]  = 16'h0002; e[63:48]  = 16'h0002;
        a[79:64]  = 16'h8001; b[79:64]  = 16'h8002; e[79:64]  = 16'h8001;
        a[95:80]  = 16'h4000; b[95:80]  = 16'hFFC1; e[95:80]  = 16'h7FC0;
        a[111:96] = 16'h8000; b[111:96] = 16'h0000; e[111:96] = 16'h0000;
        do_txn(4'd5, a, b, rand_data(), 16'h0040, 1, 0, 2, 0);
        tests++;
        if (t_timeout || t_wdata !== e) begin
            fails++; $display("FAIL fmax_special: got %h expected %h", t_wdata[111:0], e[111:0]);
        end
    endtask

    task automatic test_int_ops();
        logic [DW-1:0] a, b, e;
        do_txn(4'd1, fill(16'hFFFF), fill(16'h0002), fill(16'h0001), 16'h0200, 0, 1, 0, 0);
        tests++;
        if (t_timeout || t_wdata !== fill(16'h0002)) begin fails++; $display("FAIL uiadd3: got %h expected lanes 0002", t_wdata[63:0]); end
        do_txn(4'd3, fill(16'h0004), rand_data(), rand_data(), 16'h0201, 0, 0, 0, 0);
        e = '0; e[15:0] = 16'h0080;
        tests++;
        if (t_timeout || t_wdata !== e) begin fails++; $display("FAIL uisum: got %h expected lane0 0080 rest 0", t_wdata[63:0]); end
        do_txn(4'd0, fill(16'h8001), fill(16'h8002), rand_data(), 16'h0202, 2, 0, 1, 0);
        tests++;
        if (t_timeout || t_wdata !== fill(16'h0003)) begin fails++; $display("FAIL uiadd: got %h expected lanes 0003", t_wdata[63:0]); end
        for (int i = 0; i < 32; i++) begin
            a[i*16 +: 16] = 16'(i * 16'h0101);
            b[i*16 +: 16] = 16'h0003;
            e[i*16 +: 16] = 16'(i * 16'h0303);
        end
        a[15:0] = 16'h0123; b[15:0] = 16'h0100; e[15:0] = 16'h2300;
        do_txn(4'd2, a, b, rand_data(), 16'h0203, 0, 0, 0, 0);
        tests++;
        if (t_timeout || t_wdata !== e) begin fails++; $display("FAIL uimul: got %h expected %h", t_wdata[63:0], e[63:0]); end
    endtask

    task automatic test_reserved();
        do_txn(4'd4, rand_data(), rand_data(), rand_data(), 16'h0300, 0, 0, 0, 0);
        tests++;
        if (t_timeout || t_wdata !== '0 || t_waddr !== 16'h0300) begin
            fails++; $display("FAIL reserved_4: got %h addr %h expected zeros addr 0300", t_wdata[63:0], t_waddr);
        end
        do_txn(4'd15, rand_data(), rand_data(), rand_data(), 16'h0301, 0, 0, 0, 1);
        tests++;
        if (t_timeout || t_wdata !== '0) begin fails++; $display("FAIL reserved_15: got %h expected zeros", t_wdata[63:0]); end
    endtask

    task automatic test_stall();
        int w0;
        do_txn(4'd0, fill(16'h0010), fill(16'h0020), fill(16'h0030), 16'h0400, 0, 0, 5, 3);
        w0 = writes;
        tests++;
        if (t_timeout || t_wr_lat !== 9) begin fails++; $display("FAIL stall_exec_after_src2: got wr_lat=%0d expected 9", t_wr_lat); end
        tests++;
        if (t_wr_cycles !== 4 || t_unstable) begin
            fails++; $display("FAIL stall_hold: got cycles=%0d unstable=%0d expected 4 0", t_wr_cycles, t_unstable);
        end
        tests++;
        if (t_wdata !== fill(16'h0030)) begin fails++; $display("FAIL stall_data: got %h expected lanes 0030", t_wdata[63:0]); end
        repeat (4) @(negedge clk);
        tests++;
        if (writes !== w0 || dst_wr_en !== 1'b0) begin fails++; $display("FAIL stall_single_write: got writes=%0d expected %0d", writes, w0); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] a, b, e;
        for (int n = 0; n < 7; n++) begin
            for (int i = 0; i < 32; i++) begin
                a[i*16 +: 16] = 16'(int'($urandom_range(8, 0)) - 4);
                b[i*16 +: 16] = 16'(int'($urandom_range(8, 0)) - 4);
                e[i*16 +: 16] = ref_fmax(a[i*16 +: 16], b[i*16 +: 16]);
            end
            do_txn(4'd5, a, b, rand_data(), 16'(16'h0500 + n), n % 3, 0, n % 2, n % 2);
            tests++;
            if (t_timeout || t_wdata !== e || t_waddr !== 16'(16'h0500 + n) || t_busy) begin
                fails++; $display("FAIL b2b_%0d: got %h addr %h busy %0d expected %h addr %h", n, t_wdata[63:0], t_waddr, t_busy, e[63:0], 16'(16'h0500 + n));
            end
        end
    endtask

    task automatic test_reset_wait();
        int w0;
        w0 = writes;
        req_valid = 1'b1; req_opcode = 4'd0; req_dst_addr = 16'h0600;
        @(negedge clk);
        req_valid = 1'b0;
        tests++;
        if (src0_rd_en !== 1'b1) begin fails++; $display("FAIL rw_read: got rd_en=%b expected 1", src0_rd_en); end
        @(negedge clk);
        rst_n = 1'b0;
        src0_rvalid = 1'b1; src0_rdata = fill(16'h0001);
        @(negedge clk);
        tests++;
        if (req_ready !== 1'b0 || dst_wr_en !== 1'b0 || src0_rd_en !== 1'b0 || dst_wr_addr !== 16'h0 || dst_wr_data !== '0) begin
            fails++; $display("FAIL rw_outputs_zero: got ready=%b wr_en=%b addr=%h expected all 0", req_ready, dst_wr_en, dst_wr_addr);
        end
        rst_n = 1'b1;
        src0_rvalid = 1'b0;
        #1;
        tests++;
        if (req_ready !== 1'b1) begin fails++; $display("FAIL rw_ready_after: got %b expected 1", req_ready); end
        src1_rvalid = 1'b1; src2_rvalid = 1'b1; src1_rdata = rand_data(); src2_rdata = rand_data();
        repeat (6) @(negedge clk);
        src1_rvalid = 1'b0; src2_rvalid = 1'b0;
        tests++;
        if (writes !== w0) begin fails++; $display("FAIL rw_no_write: got writes=%0d expected %0d", writes, w0); end
        do_txn(4'd0, fill(16'h1111), fill(16'h2222), rand_data(), 16'h0601, 0, 1, 2, 0);
        tests++;
        if (t_timeout || t_wdata !== fill(16'h3333) || t_waddr !== 16'h0601) begin
            fails++; $display("FAIL rw_next_request: got %h addr %h expected lanes 3333 addr 0601", t_wdata[63:0], t_waddr);
        end
    endtask

    initial begin
        test_reset();
        test_fmax();
        test_fmax_special();
        test_int_ops();
        test_reserved();
        test_stall();
        test_back_to_back();
        test_reset_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
